// File: rtl/uart_tx_x.sv
// 8N1 UART transmitter: latch a byte with Data_Ready, start the frame with Data_Send.
// Each bit is held CLKS_PER_BIT clocks; the FSM state is visible on dbg_state.
module uart_tx_x #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic [7:0] Data_In,
    input  logic       Data_Ready,
    input  logic       Data_Send,
    output logic       Serial_Out,
    output logic       UBusy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        LOADED = 3'b001,
        SHIFT  = 3'b010
    } state_e;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [9:0]  shift_q, shift_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] baud_q, baud_d;

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            shift_q <= 10'h3FF;
            bit_q   <= 4'd0;
            baud_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        case (state_q)
            IDLE: begin
                // Data_Send is deliberately not looked at here: a byte must be latched first.
                if (Data_Ready) begin
                    data_d  = Data_In;
                    state_d = LOADED;
                end
            end
            LOADED: begin
                if (Data_Send) begin
                    shift_d = {1'b1, data_q, 1'b0};
                    bit_d   = 4'd0;
                    baud_d  = 16'd0;
                    state_d = SHIFT;
                end else if (Data_Ready) begin
                    data_d = Data_In;
                end
            end
            SHIFT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = 16'd0;
                    if (bit_q == 4'd9) begin
                        shift_d = 10'h3FF;
                        bit_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        shift_d = {1'b1, shift_q[9:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = 10'h3FF;
                bit_d   = 4'd0;
                baud_d  = 16'd0;
            end
        endcase
    end

    assign Serial_Out = shift_q[0];
    assign UBusy      = (state_q == SHIFT);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_x.sv
// Directed-plus-random bench for uart_tx_x; two instances cover CLKS_PER_BIT of 1 and 4.
module tb_uart_tx_x;

  logic       Clk = 1'b0;
  logic       RST;
  logic [7:0] din1, din4;
  logic       rdy1, snd1, rdy4, snd4;
  logic       so1, busy1, so4, busy4;
  logic [2:0] st1, st4;

  int         pass_cnt = 0;
  int         check_cnt = 0;
  logic [7:0] model_data;
  logic       exp_q[$];

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_LOADED = 3'b001;
  localparam logic [2:0] ST_SHIFT  = 3'b010;

  always #5 Clk = ~Clk;

  uart_tx_x #(.CLKS_PER_BIT(1)) dut1 (
    .Clk(Clk), .RST(RST), .Data_In(din1), .Data_Ready(rdy1), .Data_Send(snd1),
    .Serial_Out(so1), .UBusy(busy1), .dbg_state(st1)
  );

  uart_tx_x #(.CLKS_PER_BIT(4)) dut4 (
    .Clk(Clk), .RST(RST), .Data_In(din4), .Data_Ready(rdy4), .Data_Send(snd4),
    .Serial_Out(so4), .UBusy(busy4), .dbg_state(st4)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // Reference frame: start 0, data LSB first, stop 1, each bit repeated c times.
  task automatic build_frame(input logic [7:0] d, input int c);
    logic b;
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) b = 1'b0;
      else if (k == 9) b = 1'b1;
      else b = d[k-1];
      repeat (c) exp_q.push_back(b);
    end
  endtask

  task automatic load(input bit sel, input logic [7:0] d, input int cyc);
    if (sel) begin din4 = d; rdy4 = 1'b1; end
    else begin din1 = d; rdy1 = 1'b1; model_data = d; end
    repeat (cyc) tick();
    rdy1 = 1'b0;
    rdy4 = 1'b0;
  endtask

  function automatic logic [15:0] obs_of(input bit sel);
    if (sel) return {11'b0, st4, busy4, so4};
    return {11'b0, st1, busy1, so1};
  endfunction

  task automatic run_frame(input bit sel, input logic [7:0] d, input int c,
                           input bit disturb, input string tag);
    build_frame(d, c);
    if (sel) snd4 = 1'b1; else snd1 = 1'b1;
    for (int i = 0; i < 10 * c; i++) begin
      tick();
      check({tag, " bit"}, obs_of(sel), {11'b0, ST_SHIFT, 1'b1, exp_q.pop_front()});
      snd1 = 1'b0; rdy1 = 1'b0; snd4 = 1'b0; rdy4 = 1'b0;
      if (disturb && i >= 2 && i <= 6) begin
        din1 = 8'h00;
        rdy1 = (i % 2 == 1);
        snd1 = (i % 2 == 0);
      end
    end
    tick();
    check({tag, " end"}, obs_of(sel), {11'b0, ST_IDLE, 1'b0, 1'b1});
  endtask

  initial begin
    logic [7:0] d;
    RST = 1'b0;
    din1 = 8'h00; din4 = 8'h00;
    rdy1 = 1'b0; snd1 = 1'b0; rdy4 = 1'b0; snd4 = 1'b0;
    model_data = 8'h00;
    tick(); tick();
    check("reset hold", obs_of(0), {11'b0, ST_IDLE, 1'b0, 1'b1});
    RST = 1'b1;
    repeat (3) tick();
    check("after release", obs_of(0), {11'b0, ST_IDLE, 1'b0, 1'b1});

    // Reset pulse between edges, data register cleared
    load(0, 8'h3C, 1);
    check("loaded", obs_of(0), {11'b0, ST_LOADED, 1'b0, 1'b1});
    #1 RST = 1'b0;
    #1 check("async reset", obs_of(0), {11'b0, ST_IDLE, 1'b0, 1'b1});
    model_data = 8'h00;
    check("reset data", {8'h00, dut1.data_q}, {8'h00, model_data});
    #1 RST = 1'b1;
    repeat (2) tick();
    check("reset released", obs_of(0), {11'b0, ST_IDLE, 1'b0, 1'b1});

    // Nominal frame of 8'hDB
    load(0, 8'hDB, 3);
    run_frame(0, model_data, 1, 1'b0, "nominal");

    // Send alone after a frame and in idle does nothing
    snd1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("send alone", obs_of(0), {11'b0, ST_IDLE, 1'b0, 1'b1});
    end
    // Ready and send together only latch
    din1 = 8'h96; rdy1 = 1'b1; model_data = 8'h96;
    tick();
    snd1 = 1'b0; rdy1 = 1'b0;
    check("both together", obs_of(0), {11'b0, ST_LOADED, 1'b0, 1'b1});
    tick();
    check("loaded holds", obs_of(0), {11'b0, ST_LOADED, 1'b0, 1'b1});
    check("latched data", {8'h00, dut1.data_q}, {8'h00, model_data});
    run_frame(0, model_data, 1, 1'b0, "after both");

    // Inputs ignored while busy
    load(0, 8'hDB, 1);
    run_frame(0, model_data, 1, 1'b1, "busy ignore");
    check("busy data kept", {8'h00, dut1.data_q}, {8'h00, model_data});

    // Reset at bit 4 aborts the frame
    load(0, 8'hDB, 1);
    build_frame(8'hDB, 1);
    snd1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      snd1 = 1'b0;
      check("pre abort bit", obs_of(0), {11'b0, ST_SHIFT, 1'b1, exp_q.pop_front()});
    end
    #1 RST = 1'b0;
    #1 check("mid-frame reset", obs_of(0), {11'b0, ST_IDLE, 1'b0, 1'b1});
    #1 RST = 1'b1;
    tick();
    check("post abort idle", obs_of(0), {11'b0, ST_IDLE, 1'b0, 1'b1});
    load(0, 8'h55, 1);
    run_frame(0, model_data, 1, 1'b0, "after abort");

    // Random bytes, optional re-latch in LOADED, random gaps
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom_range(0, 255));
      load(0, d, $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom_range(0, 255));
        load(0, d, 1);
      end
      repeat ($urandom_range(0, 3)) tick();
      check("rand loaded", obs_of(0), {11'b0, ST_LOADED, 1'b0, 1'b1});
      run_frame(0, model_data, 1, 1'b0, "random");
    end

    // Slower baud instance
    load(1, 8'hA5, 1);
    check("baud loaded", obs_of(1), {11'b0, ST_LOADED, 1'b0, 1'b1});
    run_frame(1, 8'hA5, 4, 1'b0, "baud A5");
    d = 8'($urandom_range(0, 255));
    load(1, d, 2);
    run_frame(1, d, 4, 1'b0, "baud random");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_x.md
UART_TX_X -- requirements
Module: uart_tx_x

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT with default 1, giving the number of Clk cycles each serial bit is held (legal range 1..65535).
REQ-002 The module SHALL have port Clk, input, 1 bit: the single system clock; all state updates occur on the rising edge.
REQ-003 The module SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port Data_In, input, 8 bits: parallel byte to transmit.
REQ-005 The module SHALL have port Data_Ready, input, 1 bit: request to latch Data_In into the data register.
REQ-006 The module SHALL have port Data_Send, input, 1 bit: request to start transmitting the latched byte.
REQ-007 The module SHALL have port Serial_Out, output, 1 bit: serial line, idle high.
REQ-008 The module SHALL have port UBusy, output, 1 bit: high while a frame is being shifted out.

Function
REQ-009 The module SHALL hold an 8-bit data register, a 10-bit shift register, a 4-bit bit counter, a baud-tick counter and a 3-bit state register.
REQ-010 The state machine SHALL have states IDLE=3'b000, LOADED=3'b001 and SHIFT=3'b010; any other encoding SHALL go to IDLE on the next edge.
REQ-011 In IDLE, Data_Ready=1 SHALL latch Data_In into the data register and move to LOADED; Data_Send alone SHALL be ignored.
REQ-012 In IDLE with Data_Ready=1 and Data_Send=1 together, the module SHALL only latch the data and move to LOADED.
REQ-013 In LOADED, Data_Send=1 SHALL load the shift register with {1'b1 stop, data[7:0], 1'b0 start}, clear both counters and move to SHIFT; the data register SHALL NOT be updated on that edge.
REQ-014 In LOADED, Data_Ready=1 with Data_Send=0 SHALL re-latch Data_In and stay in LOADED.
REQ-015 Serial_Out SHALL equal shift register bit 0, so bits go out LSB first: start bit, data[0]..data[7], stop bit.
REQ-016 In SHIFT, the shift register SHALL shift right with 1 filled into bit 9, and the bit counter SHALL increment once every CLKS_PER_BIT cycles.
REQ-017 After the 10th bit has been held for CLKS_PER_BIT cycles, the module SHALL return to IDLE with the shift register all ones.
REQ-018 A 10-bit frame SHALL therefore occupy exactly 10*CLKS_PER_BIT cycles, from the edge that samples Data_Send to the edge that returns to IDLE.
REQ-019 UBusy SHALL be 1 exactly while the state is SHIFT, and 0 in IDLE and LOADED.
REQ-020 Data_Ready and Data_Send SHALL be ignored during SHIFT, leaving the frame in flight and the data register unchanged.
REQ-021 Serial_Out SHALL be 1 in IDLE and LOADED.
REQ-022 A new frame SHALL require a fresh Data_Ready in IDLE; Data_Send alone after a frame completes SHALL NOT retransmit.

Reset
REQ-023 While RST=0, asynchronously: state IDLE, data register 8'h00, shift register 10'h3FF, counters 0, Serial_Out=1, UBusy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with the line returning to 1 without waiting for a clock edge.
REQ-025 After RST rises, the first active edge SHALL behave as in IDLE.

Verification
REQ-026 Reset: pulse RST low between clock edges -> Serial_Out=1, UBusy=0, state 000 immediately, and these hold after release.
REQ-027 Nominal (CLKS_PER_BIT=1): Data_In=8'hDB, Data_Ready=1 for 3 cycles, then Data_Send=1 -> from the Send-sampling edge Serial_Out per cycle = 0,1,1,0,1,1,0,1,1,1; UBusy=1 for exactly 10 cycles, then Serial_Out=1 and UBusy=0.
REQ-028 Ordering: Data_Send=1 in IDLE with no prior Data_Ready -> no frame, Serial_Out=1, UBusy=0; both asserted together -> LOADED only.
REQ-029 Busy-ignore: during a frame of 8'hDB, apply Data_In=8'h00 with Data_Ready and Data_Send pulses -> frame unchanged; after completion the data register still holds 8'hDB and the state is IDLE.
REQ-030 Mid-frame reset: assert RST=0 at bit 4 -> Serial_Out=1 and UBusy=0 asynchronously; a following load/send of 8'h55 -> frame 0,1,0,1,0,1,0,1,0,1.
REQ-031 Baud: CLKS_PER_BIT=4, byte 8'hA5 -> each bit held 4 cycles, UBusy high for 40 cycles, bit sequence 0,1,0,1,0,0,1,0,1,1.
